// File: rtl/lm70_reader_if.sv
// rtl/lm70_reader_if.sv - LM70 reader host/sensor signal bundle
interface lm70_reader_if;
    logic        start;
    logic        sio;
    logic        cs;
    logic        sck;
    logic [15:0] data;
    logic        valid;
    logic        busy;

    // Reader side: drives the sensor pins and the result word.
    modport master (
        input  start,
        input  sio,
        output cs,
        output sck,
        output data,
        output valid,
        output busy
    );

    // Host/sensor side.
    modport slave (
        output start,
        output sio,
        input  cs,
        input  sck,
        input  data,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/lm70_reader.sv
// rtl/lm70_reader.sv - LM70 16-bit serial read engine; optional auto-poll under LM70_AUTO_POLL_EN
module lm70_reader #(
    parameter int CLK_DIV     = 4,
    parameter int POLL_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    lm70_reader_if.master      io_bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] C_HMAX = 8'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("lm70_reader: CLK_DIV must be 1..255");
    end
    if (POLL_CYCLES < 1) begin : g_bad_poll
        $error("lm70_reader: POLL_CYCLES must be >= 1");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [4:0]  r_bits;
    logic [15:0] r_shreg;
    logic [15:0] r_data;
    logic        r_cs;
    logic        r_sck;
    logic        r_valid;

    logic        w_tick;
    logic        w_fall;
    logic        w_last;
    logic        w_load;
    logic        w_start;
    logic        w_cs_nxt;
    logic        w_sck_nxt;
    logic        w_valid_nxt;

    // Phase boundary: the half-period counter has run out.
    assign w_tick = (r_cnt == 8'd0);
    // Edge that drives SCK 1->0; the sensor's bit is stable here.
    assign w_fall = (r_state == S_SHIFT) && w_tick && r_sck;
    assign w_last = w_fall && (r_bits == 5'd15);
    assign w_load = (r_state == S_HOLD) && w_tick;

`ifdef LM70_AUTO_POLL_EN
    logic [31:0] r_poll;
    logic        w_poll_hit;

    assign w_poll_hit = (r_state == S_IDLE) && (r_poll == 32'(POLL_CYCLES - 1));
    assign w_start    = io_bus.start | w_poll_hit;

    // Idle-time poll counter; any start (manual or automatic) restarts the interval.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_poll <= 32'd0;
        end else if (r_state != S_IDLE || w_start) begin
            r_poll <= 32'd0;
        end else begin
            r_poll <= r_poll + 32'd1;
        end
    end
`else
    assign w_start = io_bus.start;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: each non-idle phase lasts a whole number of half-periods.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SETUP;
            S_SETUP: if (w_tick)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)  w_state_nxt = S_HOLD;
            S_HOLD:  if (w_tick)  w_state_nxt = S_GAP;
            S_GAP:   if (w_tick)  w_state_nxt = S_IDLE;
            default:              w_state_nxt = S_IDLE;
        endcase
    end

    // Half-period down-counter, reloaded at every phase boundary, parked at 0 in IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 8'd0;
        end else if (w_state_nxt == S_IDLE) begin
            r_cnt <= 8'd0;
        end else if (w_tick) begin
            r_cnt <= C_HMAX;
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // Count SCK falling edges so SHIFT ends after the 16th one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bits <= 5'd0;
        end else if (r_state != S_SHIFT) begin
            r_bits <= 5'd0;
        end else if (w_fall) begin
            r_bits <= r_bits + 5'd1;
        end
    end

    // Receive shifter: cleared at start, MSB arrives first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg <= 16'h0000;
        end else if (r_state == S_IDLE && w_start) begin
            r_shreg <= 16'h0000;
        end else if (w_fall) begin
            r_shreg <= {r_shreg[14:0], io_bus.sio};
        end
    end

    // Result word only changes once a full transfer has completed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= 16'h0000;
        end else if (w_load) begin
            r_data <= r_shreg;
        end
    end

    // Next values of the registered pins, derived from the upcoming state.
    always_comb begin
        w_cs_nxt    = 1'b1;
        w_sck_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        if (w_state_nxt == S_SETUP || w_state_nxt == S_SHIFT || w_state_nxt == S_HOLD) begin
            w_cs_nxt = 1'b0;
        end
        case (r_state)
            S_SETUP: w_sck_nxt = w_tick;
            S_SHIFT: w_sck_nxt = w_tick ? ~r_sck : r_sck;
            default: w_sck_nxt = 1'b0;
        endcase
        w_valid_nxt = w_load;
    end

    // Pin registers, so CS/SCK are glitch-free and VALID is a clean one-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cs    <= 1'b1;
            r_sck   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_cs    <= w_cs_nxt;
            r_sck   <= w_sck_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign io_bus.cs    = r_cs;
    assign io_bus.sck   = r_sck;
    assign io_bus.data  = r_data;
    assign io_bus.valid = r_valid;
    assign io_bus.busy  = (r_state != S_IDLE);

endmodule
